// File: rtl/aix_dma_pkg.sv
// Shared definitions for the conv write-back DMA: default geometry, width helpers,
// buffer-select decode and the ping-pong bank encoding.
package aix_dma_pkg;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned MAC_DATA_WD_DEF  = 32;
    localparam int unsigned PACK_DEF         = 4;
    localparam int unsigned BUF_NUM_DEF      = 16;
    localparam int unsigned ROWS_DEF         = 4;
    localparam int unsigned COLS_DEF         = 32;
    localparam int unsigned BRAM_DATA_WD_DEF = PACK_DEF * MAC_DATA_WD_DEF;
    localparam int unsigned ADDR_WIDTH_DEF   = 1 + $clog2(COLS_DEF);

    // Upper bound on BUF_NUM supported by the decode helper.
    localparam int unsigned MAX_BUF_W = 6;
    localparam int unsigned MAX_BUF   = 1 << MAX_BUF_W;

    typedef enum logic {
        Bank0 = 1'b0,
        Bank1 = 1'b1
    } bank_e;

    function automatic logic [MAX_BUF-1:0] onehot(input int unsigned idx);
        logic [MAX_BUF-1:0] m;
        m = '0;
        m[idx[MAX_BUF_W-1:0]] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/dma_pack_acc.sv
// Packs PACK accepted MAC beats into one word (beat 0 in the LSBs); a flush closes a
// partial word with the unfilled lanes left at zero.
module dma_pack_acc
    import aix_dma_pkg::*;
#(
    parameter int unsigned DATA_WD = MAC_DATA_WD_DEF,
    parameter int unsigned PACK    = PACK_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      accept,
    input  logic [DATA_WD-1:0]        data,
    input  logic                      flush,
    output logic [PACK*DATA_WD-1:0]   word,
    output logic                      word_done
);

    localparam int unsigned BeatW = cnt_w(PACK);

    logic [BeatW-1:0]        beat_q;
    logic [PACK*DATA_WD-1:0] word_q;
    logic                    last_beat;

    always_comb begin
        word = word_q;
        for (int k = 0; k < PACK; k++) begin
            if (accept && beat_q == BeatW'(k)) begin
                word[k*DATA_WD +: DATA_WD] = data;
            end
        end
        last_beat = accept && (beat_q == BeatW'(PACK - 1));
        // A flush closes the word only if it holds at least one beat.
        word_done = last_beat || (flush && (accept || beat_q != '0));
    end

    // word_q is cleared on every completion so unfilled lanes read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            word_q <= '0;
        end else if (word_done) begin
            beat_q <= '0;
            word_q <= '0;
        end else if (accept) begin
            beat_q <= beat_q + 1'b1;
            word_q <= word;
        end
    end

endmodule

// File: rtl/dma_conv_wr.sv
// Write-back DMA from the MAC array into banked Global Buffer-B BRAMs, with a
// two-bank ping-pong region released by the consumer.
module dma_conv_wr
    import aix_dma_pkg::*;
#(
    parameter int unsigned MAC_DATA_WD = MAC_DATA_WD_DEF,
    parameter int unsigned PACK        = PACK_DEF,
    parameter int unsigned BUF_NUM     = BUF_NUM_DEF,
    parameter int unsigned ROWS        = ROWS_DEF,
    parameter int unsigned COLS        = COLS_DEF,
    localparam int unsigned BRAM_DATA_WD = PACK * MAC_DATA_WD,
    localparam int unsigned ADDR_WIDTH   = 1 + $clog2(COLS)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    input  logic [MAC_DATA_WD-1:0]          i_data,
    output logic                            o_ready,
    input  logic                            i_flush,
    input  logic                            i_release,
    input  logic                            i_release_bank,
    output logic [BUF_NUM-1:0]              o_bram_we,
    output logic [BUF_NUM*ADDR_WIDTH-1:0]   o_bram_addr,
    output logic [BUF_NUM*BRAM_DATA_WD-1:0] o_bram_data,
    output logic [1:0]                      o_bank_full,
    output logic                            o_bank_done
);

    localparam int unsigned LANES = BUF_NUM / ROWS;
    localparam int unsigned LaneW = cnt_w(LANES);
    localparam int unsigned RowW  = cnt_w(ROWS);
    localparam int unsigned ColW  = $clog2(COLS);

    logic [LaneW-1:0]        lane_q, lane_d;
    logic [ColW-1:0]         col_q, col_d;
    logic [RowW-1:0]         row_q, row_d;
    bank_e                   bank_q, bank_d;
    logic [1:0]              full_q, full_d;
    logic                    done_q, done_d;
    logic [BUF_NUM-1:0]      we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [BRAM_DATA_WD-1:0] wdata_q, wdata_d;

    logic                    accept;
    logic                    word_done;
    logic [BRAM_DATA_WD-1:0] word;
    int unsigned             sel;

    assign o_ready = !full_q[bank_q];
    assign accept  = i_valid && o_ready;

    dma_pack_acc #(
        .DATA_WD (MAC_DATA_WD),
        .PACK    (PACK)
    ) u_pack (
        .clk       (i_clk),
        .rst       (i_rst),
        .accept    (accept),
        .data      (i_data),
        .flush     (i_flush),
        .word      (word),
        .word_done (word_done)
    );

    always_comb begin
        lane_d  = lane_q;
        col_d   = col_q;
        row_d   = row_q;
        bank_d  = bank_q;
        full_d  = full_q;
        done_d  = 1'b0;
        we_d    = '0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        sel     = 32'(row_q) * LANES + 32'(lane_q);
        // Release is applied first so that a fill of the same bank wins.
        if (i_release) begin
            full_d[i_release_bank] = 1'b0;
        end
        if (word_done) begin
            we_d    = BUF_NUM'(onehot(sel));
            waddr_d = {bank_q, col_q};
            wdata_d = word;
            if (lane_q == LaneW'(LANES - 1)) begin
                lane_d = '0;
                if (col_q == ColW'(COLS - 1)) begin
                    col_d = '0;
                    if (row_q == RowW'(ROWS - 1)) begin
                        row_d          = '0;
                        full_d[bank_q] = 1'b1;
                        done_d         = 1'b1;
                        bank_d         = (bank_q == Bank0) ? Bank1 : Bank0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lane_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            bank_q  <= Bank0;
            full_q  <= '0;
            done_q  <= 1'b0;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            lane_q  <= lane_d;
            col_q   <= col_d;
            row_q   <= row_d;
            bank_q  <= bank_d;
            full_q  <= full_d;
            done_q  <= done_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Address/data are gated by the registered strobe, so idle slices read as zero.
    for (genvar g = 0; g < BUF_NUM; g++) begin : g_slice
        assign o_bram_addr[g*ADDR_WIDTH +: ADDR_WIDTH]     = we_q[g] ? waddr_q : '0;
        assign o_bram_data[g*BRAM_DATA_WD +: BRAM_DATA_WD] = we_q[g] ? wdata_q : '0;
    end

    assign o_bram_we   = we_q;
    assign o_bank_full = full_q;
    assign o_bank_done = done_q;

endmodule

// File: tb/tb_dma_conv_wr.sv
// Scoreboard bench for dma_conv_wr: directed stimulus pushes expected writes, a monitor
// pops and compares them whenever a write strobe is presented.
module tb_dma_conv_wr;
    import aix_dma_pkg::*;

    localparam int unsigned DW  = MAC_DATA_WD_DEF;
    localparam int unsigned BUF = BUF_NUM_DEF;
    localparam int unsigned AW  = ADDR_WIDTH_DEF;
    localparam int unsigned BW  = BRAM_DATA_WD_DEF;

    logic              i_clk = 1'b0;
    logic              i_rst, i_valid, i_flush, i_release, i_release_bank;
    logic [DW-1:0]     i_data;
    logic              o_ready;
    logic [BUF-1:0]    o_bram_we;
    logic [BUF*AW-1:0] o_bram_addr;
    logic [BUF*BW-1:0] o_bram_data;
    logic [1:0]        o_bank_full;
    logic              o_bank_done;

    dma_conv_wr dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .o_ready        (o_ready),
        .i_flush        (i_flush),
        .i_release      (i_release),
        .i_release_bank (i_release_bank),
        .o_bram_we      (o_bram_we),
        .o_bram_addr    (o_bram_addr),
        .o_bram_data    (o_bram_data),
        .o_bank_full    (o_bank_full),
        .o_bank_done    (o_bank_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int unsigned   sel;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic          done;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   writes   = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the oldest expectation.
    always @(negedge i_clk) begin
        exp_t              e;
        logic [BUF*AW-1:0] oa;
        logic [BUF*BW-1:0] od;
        if (o_bram_we != '0) begin
            writes++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got we=%h expected no write", o_bram_we);
            end else begin
                e = sb.pop_front();
                chk("we", BW'(o_bram_we), BW'(16'd1 << e.sel));
                chk("addr", BW'(o_bram_addr[e.sel*AW +: AW]), BW'(e.addr));
                chk("data", o_bram_data[e.sel*BW +: BW], e.data);
                chk("done_with_write", BW'(o_bank_done), BW'(e.done));
                oa = o_bram_addr;
                od = o_bram_data;
                oa[e.sel*AW +: AW] = '0;
                od[e.sel*BW +: BW] = '0;
                chk("other_slices_zero", BW'(oa == '0 && od == '0), BW'(1));
            end
        end else if (o_bank_done) begin
            checks++;
            failures++;
            $display("FAIL done_without_write: got done=1 expected 0");
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst     = 1'b1;
        i_valid   = 1'b0;
        i_flush   = 1'b0;
        i_release = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic push(input int unsigned sel, input logic [AW-1:0] addr,
                        input logic [BW-1:0] data, input logic done);
        exp_t e;
        e.sel  = sel;
        e.addr = addr;
        e.data = data;
        e.done = done;
        sb.push_back(e);
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic fl);
        i_valid = 1'b1;
        i_data  = d;
        i_flush = fl;
        tick();
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input int bank, input int w, input int b);
        return DW'(32'h1000_0000 * (bank + 1) + w * 16 + b);
    endfunction

    // Streams one beat per cycle from word `first` to the end of the bank; optionally
    // releases bank 1 on the very last beat.
    task automatic stream_bank(input int bank, input int first, input bit rel_last);
        logic [BW-1:0] word;
        logic [AW-1:0] addr;
        for (int w = first; w < 512; w++) begin
            for (int b = 0; b < 4; b++) word[b*DW +: DW] = pat(bank, w, b);
            addr = AW'(bank * 32 + (w / 4) % 32);
            push((w / 128) * 4 + w % 4, addr, word, w == 511);
            for (int b = 0; b < 4; b++) begin
                i_valid = 1'b1;
                i_data  = pat(bank, w, b);
                if (rel_last && w == 511 && b == 3) begin
                    i_release      = 1'b1;
                    i_release_bank = 1'b1;
                end
                tick();
            end
        end
        i_valid   = 1'b0;
        i_release = 1'b0;
    endtask

    int wbase;

    initial begin
        i_release_bank = 1'b0;
        i_data         = '0;
        do_reset();

        // Reset state.
        chk("rst_ready", BW'(o_ready), BW'(1));
        chk("rst_full", BW'(o_bank_full), BW'(0));
        chk("rst_done", BW'(o_bank_done), BW'(0));
        chk("rst_we", BW'(o_bram_we), BW'(0));
        chk("rst_addr_data_zero", BW'(o_bram_addr == '0 && o_bram_data == '0), BW'(1));

        // Releasing a bank that is not full changes nothing.
        i_release      = 1'b1;
        i_release_bank = 1'b1;
        tick();
        i_release = 1'b0;
        chk("idle_release_full", BW'(o_bank_full), BW'(0));
        chk("idle_release_ready", BW'(o_ready), BW'(1));

        // Basic four-beat word.
        push(0, 6'h00, 128'h00000044_00000033_00000022_00000011, 1'b0);
        beat(32'h11, 1'b0);
        beat(32'h22, 1'b0);
        beat(32'h33, 1'b0);
        beat(32'h44, 1'b0);
        tick();
        tick();

        // Flush cases.
        do_reset();
        push(0, 6'h00, 128'h00000000_00000000_0000000B_0000000A, 1'b0);
        beat(32'hA, 1'b0);
        beat(32'hB, 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        push(1, 6'h00, 128'h00000014_00000013_00000012_00000011, 1'b0);
        beat(32'h11, 1'b0);
        beat(32'h12, 1'b0);
        beat(32'h13, 1'b0);
        beat(32'h14, 1'b0);
        i_flush = 1'b1;            // empty word: no write expected
        tick();
        i_flush = 1'b0;
        push(2, 6'h00, 128'h00000000_00000000_00000000_0000000C, 1'b0);
        beat(32'hC, 1'b1);
        push(3, 6'h00, 128'h00000024_00000023_00000022_00000021, 1'b0);
        beat(32'h21, 1'b0);
        beat(32'h22, 1'b0);
        beat(32'h23, 1'b0);
        beat(32'h24, 1'b1);
        push(0, 6'h01, 128'h00000034_00000033_00000032_00000031, 1'b0);
        beat(32'h31, 1'b0);
        beat(32'h32, 1'b0);
        beat(32'h33, 1'b0);
        beat(32'h34, 1'b0);
        tick();
        tick();

        // Reset in the middle of a bank and a word.
        do_reset();
        push(0, 6'h00, 128'h00000044_00000043_00000042_00000041, 1'b0);
        beat(32'h41, 1'b0);
        beat(32'h42, 1'b0);
        beat(32'h43, 1'b0);
        beat(32'h44, 1'b0);
        beat(32'h51, 1'b0);
        beat(32'h52, 1'b0);
        i_valid = 1'b1;
        i_data  = 32'h53;
        i_rst   = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        chk("midrst_we", BW'(o_bram_we), BW'(0));
        chk("midrst_full", BW'(o_bank_full), BW'(0));
        chk("midrst_done", BW'(o_bank_done), BW'(0));
        chk("midrst_ready", BW'(o_ready), BW'(1));
        chk("midrst_addr_data_zero", BW'(o_bram_addr == '0 && o_bram_data == '0), BW'(1));
        push(0, 6'h00, 128'h00000064_00000063_00000062_00000061, 1'b0);
        beat(32'h61, 1'b0);
        beat(32'h62, 1'b0);
        beat(32'h63, 1'b0);
        beat(32'h64, 1'b0);
        tick();
        tick();

        // Full bank 0, then bank 1 with no release.
        do_reset();
        wbase = writes;
        stream_bank(0, 0, 1'b0);
        chk("bank0_full", BW'(o_bank_full), BW'(2'b01));
        chk("bank0_done", BW'(o_bank_done), BW'(1));
        chk("bank0_ready", BW'(o_ready), BW'(1));
        tick();
        chk("bank0_done_pulse", BW'(o_bank_done), BW'(0));
        chk("bank0_writes", BW'(writes - wbase), BW'(512));
        stream_bank(1, 0, 1'b0);
        chk("both_full", BW'(o_bank_full), BW'(2'b11));
        chk("both_ready_low", BW'(o_ready), BW'(0));
        chk("bank1_done", BW'(o_bank_done), BW'(1));
        tick();
        wbase = writes;
        i_valid = 1'b1;
        i_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) tick();
        i_valid = 1'b0;
        chk("stalled_ready", BW'(o_ready), BW'(0));
        chk("stalled_no_writes", BW'(writes - wbase), BW'(0));

        // Release bank 0 and refill it; release bank 1 as bank 0 fills.
        i_release      = 1'b1;
        i_release_bank = 1'b0;
        tick();
        i_release = 1'b0;
        chk("rel0_ready", BW'(o_ready), BW'(1));
        chk("rel0_full", BW'(o_bank_full), BW'(2'b10));
        stream_bank(0, 0, 1'b1);
        chk("swap_full", BW'(o_bank_full), BW'(2'b01));
        chk("swap_ready", BW'(o_ready), BW'(1));
        chk("swap_done", BW'(o_bank_done), BW'(1));
        tick();
        tick();
        tick();
        chk("scoreboard_empty", BW'(sb.size()), BW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
